// File: rtl/pkt_header_insert_pkg.sv
// Shared definitions for the packet header inserter: FSM encoding, header field map, magic default.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pkt_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    localparam int HDR_W     = 128;
    localparam int MAGIC_LSB = 112;
    localparam int MAGIC_W   = 16;
    localparam int SID_LSB   = 96;
    localparam int SID_W     = 16;
    localparam int SEQ_LSB   = 64;
    localparam int SEQ_W     = 32;
    localparam int TS_LSB    = 0;
    localparam int TS_W      = 64;

    localparam logic [MAGIC_W-1:0] DEFAULT_MAGIC = 16'hDDC0;

    // Assemble a header beat from its fields at their fixed offsets.
    function automatic logic [HDR_W-1:0] build_header(
        input logic [MAGIC_W-1:0] magic,
        input logic [SID_W-1:0]   sid,
        input logic [SEQ_W-1:0]   seq,
        input logic [TS_W-1:0]    ts
    );
        logic [HDR_W-1:0] h;
        h = '0;
        h[MAGIC_LSB +: MAGIC_W] = magic;
        h[SID_LSB   +: SID_W]   = sid;
        h[SEQ_LSB   +: SEQ_W]   = seq;
        h[TS_LSB    +: TS_W]    = ts;
        return h;
    endfunction

endpackage

// File: rtl/pkt_header_insert_if.sv
// 128-bit AXI-Stream beat bundle (data, valid, last, ready) for the header inserter ports.
// Latency: n/a (wires only).
// Backpressure: tready flows from slave back to master.
interface pkt_header_insert_if;
    import pkt_hdr_pkg::*;

    logic [HDR_W-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface

// File: rtl/pkt_header_insert.sv
// Prepends a header beat (magic, stream id, seq, timestamp) to each packet; truncates at max_beats.
// Latency: header appears 1 cycle after first valid beat seen in IDLE; payload is zero-latency pass-through.
// Backpressure: header held until m_axis.tready; in payload s_axis.tready follows m_axis.tready.
module pkt_header_insert
    import pkt_hdr_pkg::*;
#(
    parameter int                 C_WIDTH = 32,
    parameter logic [MAGIC_W-1:0] C_MAGIC = DEFAULT_MAGIC
) (
    input  logic                s_axis_aclk,
    input  logic                s_axis_areset,
    input  logic                enable,
    input  logic [SID_W-1:0]    stream_id,
    input  logic [C_WIDTH-1:0]  max_beats,
    pkt_header_insert_if.slave  s_axis,
    pkt_header_insert_if.master m_axis,
    output logic [SEQ_W-1:0]    seq_num,
    output logic                trunc_err
);

    state_t             state_q;
    state_t             state_d;
    logic [TS_W-1:0]    ts_q;
    logic [HDR_W-1:0]   hdr_q;
    logic [C_WIDTH-1:0] beat_cnt;

    logic at_limit;
    logic pay_last;
    logic start_pkt;
    logic hdr_acc;
    logic pay_hs;

    // The limit compare is against max_beats-1 because beat_cnt counts beats already accepted.
    assign at_limit  = (max_beats != '0) && (beat_cnt == max_beats - C_WIDTH'(1));
    assign pay_last  = s_axis.tlast | at_limit;
    assign start_pkt = (state_q == ST_IDLE) && s_axis.tvalid && enable;
    assign hdr_acc   = (state_q == ST_HEADER) && m_axis.tready;
    assign pay_hs    = (state_q == ST_PAYLOAD) && s_axis.tvalid && m_axis.tready;

    // State register.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: idle -> header on a gated start, header -> payload on accept, payload -> idle on last beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_pkt)          state_d = ST_HEADER;
            ST_HEADER:  if (hdr_acc)            state_d = ST_PAYLOAD;
            ST_PAYLOAD: if (pay_hs && pay_last) state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // Output mux: nothing in idle, registered header, or straight pass-through in payload.
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tvalid = 1'b0;
        m_axis.tlast  = 1'b0;
        s_axis.tready = 1'b0;
        unique case (state_q)
            ST_HEADER: begin
                m_axis.tdata  = hdr_q;
                m_axis.tvalid = 1'b1;
            end
            ST_PAYLOAD: begin
                m_axis.tdata  = s_axis.tdata;
                m_axis.tvalid = s_axis.tvalid;
                m_axis.tlast  = pay_last;
                s_axis.tready = m_axis.tready;
            end
            default: ;
        endcase
    end

    // Free-running timestamp, wraps naturally at 2^64.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Capture the header at packet start so it stays stable while downstream stalls.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            hdr_q <= '0;
        end else if (start_pkt) begin
            hdr_q <= build_header(C_MAGIC, stream_id, seq_num, ts_q);
        end
    end

    // Beat count per packet, sequence number per completed packet, sticky truncation flag.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            beat_cnt  <= '0;
            seq_num   <= '0;
            trunc_err <= 1'b0;
        end else begin
            if (hdr_acc) begin
                beat_cnt <= '0;
            end else if (pay_hs) begin
                beat_cnt <= beat_cnt + C_WIDTH'(1);
            end
            if (pay_hs && pay_last) begin
                seq_num <= seq_num + SEQ_W'(1);
                if (!s_axis.tlast) begin
                    trunc_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pkt_header_insert.sv
// Self-checking bench for pkt_header_insert: table rows, random streams vs. a packet-level model, corner sequences.
// Latency: n/a (testbench).
// Backpressure: bench drives m_axis tready in always-on, toggling and random patterns.
module tb_pkt_header_insert;

    localparam logic [15:0] MAGIC = 16'hDDC0;

    typedef struct {
        logic [127:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        bit           hdr;
        logic [127:0] d;
        logic         l;
    } obeat_t;

    typedef struct {
        int          nb;
        int unsigned maxb;
        int          rmode;
        logic [15:0] sid;
        int          exp_out;
        int          exp_seq;
        bit          exp_trunc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] stream_id = '0;
    logic [31:0] max_beats = '0;
    logic [31:0] seq_num;
    logic        trunc_err;
    logic [63:0] cyc;

    pkt_header_insert_if s_if ();
    pkt_header_insert_if m_if ();

    pkt_header_insert #(.C_WIDTH(32), .C_MAGIC(16'hDDC0)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .enable        (enable),
        .stream_id     (stream_id),
        .max_beats     (max_beats),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .seq_num       (seq_num),
        .trunc_err     (trunc_err)
    );

    always #5 clk = ~clk;

    // Cycles elapsed since reset release; the timestamp should always equal this.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 64'd1;
    end

    int checks   = 0;
    int failures = 0;

    beat_t       in_q[$];
    obeat_t      got_q[$];
    obeat_t      exp_q[$];
    longint      hdr_cyc[$];
    logic [31:0] m_seq;
    bit          m_trunc;
    vec_t        tbl[6];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t mk_beat(input bit last);
        beat_t b;
        b.d = {$urandom, $urandom, $urandom, $urandom};
        b.d[127:124] = 4'h0;   // keeps payload distinguishable from a header
        b.l = last;
        return b;
    endfunction

    task automatic add_packet(input int n);
        for (int i = 0; i < n; i++) in_q.push_back(mk_beat(i == n - 1));
    endtask

    // Packet-level reference: header before each packet, last on tlast or at the beat limit.
    task automatic model_build(input beat_t b[$], input int unsigned maxb, input logic [15:0] sid);
        int unsigned cnt;
        bit          in_pkt;
        obeat_t      o;
        cnt = 0;
        in_pkt = 0;
        foreach (b[i]) begin
            if (!in_pkt) begin
                o.hdr = 1'b1;
                o.d   = {MAGIC, sid, m_seq, 64'h0};
                o.l   = 1'b0;
                exp_q.push_back(o);
                in_pkt = 1;
                cnt = 0;
            end
            cnt++;
            o.hdr = 1'b0;
            o.d   = b[i].d;
            o.l   = b[i].l || (maxb != 0 && cnt == maxb);
            exp_q.push_back(o);
            if (o.l) begin
                if (!b[i].l) m_trunc = 1;
                m_seq  = m_seq + 32'd1;
                in_pkt = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        int n;
        chk("out_count", 160'(got_q.size()), 160'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (exp_q[i].hdr)
                chk($sformatf("hdr_beat%0d", i),
                    {95'h0, got_q[i].hdr, got_q[i].d[127:64], got_q[i].l},
                    {95'h0, exp_q[i].hdr, exp_q[i].d[127:64], exp_q[i].l});
            else
                chk($sformatf("data_beat%0d", i),
                    {30'h0, got_q[i].hdr, got_q[i].d, got_q[i].l},
                    {30'h0, exp_q[i].hdr, exp_q[i].d, exp_q[i].l});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Drive in_q into the DUT and record output beats; protocol checks every cycle.
    task automatic run_stream(input int rmode, input int vgap, input int drop_en_after);
        int           budget;
        int           accepted;
        bit           prev_hdr;
        bit           prev_rdy;
        bit           vld_hold;
        bit           is_hdr;
        logic [127:0] prev_dat;
        budget = 0;
        accepted = 0;
        prev_hdr = 0;
        prev_rdy = 0;
        vld_hold = 0;
        prev_dat = '0;
        while (in_q.size() > 0 && budget < 5000) begin
            @(negedge clk);
            case (rmode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = budget[0] ? 1'b0 : 1'b1;
                default: m_if.tready = ($urandom_range(0, 3) != 0);
            endcase
            if (!vld_hold) s_if.tvalid = ($urandom_range(0, 99) >= vgap);
            s_if.tdata = in_q[0].d;
            s_if.tlast = in_q[0].l;
            #1;
            is_hdr = m_if.tvalid && (m_if.tdata[127:112] == MAGIC);
            if (is_hdr && !prev_hdr) begin
                chk("hdr_ts", 160'(m_if.tdata[63:0]), 160'(cyc - 64'd1));
                hdr_cyc.push_back(longint'(cyc));
            end
            if (is_hdr && prev_hdr && !prev_rdy)
                chk("hdr_stable", 160'(m_if.tdata), 160'(prev_dat));
            if (s_if.tready)
                chk("passthru", {29'h0, m_if.tready, m_if.tvalid, m_if.tdata, s_if.tlast},
                                {29'h0, 1'b1, s_if.tvalid, s_if.tdata, s_if.tlast});
            if (m_if.tvalid && m_if.tready) got_q.push_back('{is_hdr, m_if.tdata, m_if.tlast});
            if (s_if.tvalid && s_if.tready) begin
                void'(in_q.pop_front());
                accepted++;
                vld_hold = 0;
                if (accepted == drop_en_after) enable = 1'b0;
            end else begin
                vld_hold = s_if.tvalid;
            end
            prev_hdr = is_hdr;
            prev_rdy = m_if.tready;
            prev_dat = m_if.tdata;
            budget++;
        end
        if (in_q.size() > 0) begin
            chk("stream_timeout", 160'(in_q.size()), 160'(0));
            in_q.delete();
        end
        @(negedge clk);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", {157'h0, m_if.tvalid, m_if.tlast, s_if.tready}, 160'h0);
        chk("rst_tdata", 160'(m_if.tdata), 160'h0);
        chk("rst_seq", 160'(seq_num), 160'h0);
        chk("rst_trunc", 160'(trunc_err), 160'h0);
        rst = 1'b0;
        m_seq = '0;
        m_trunc = 0;
        got_q.delete();
        exp_q.delete();
        hdr_cyc.delete();
    endtask

    initial begin
        int n;
        bit seen;

        tbl[0] = '{nb: 4, maxb: 0, rmode: 0, sid: 16'h0003, exp_out: 5, exp_seq: 1, exp_trunc: 0};
        tbl[1] = '{nb: 5, maxb: 3, rmode: 0, sid: 16'h0011, exp_out: 7, exp_seq: 2, exp_trunc: 1};
        tbl[2] = '{nb: 1, maxb: 0, rmode: 0, sid: 16'h0022, exp_out: 2, exp_seq: 1, exp_trunc: 0};
        tbl[3] = '{nb: 3, maxb: 1, rmode: 0, sid: 16'h0033, exp_out: 6, exp_seq: 3, exp_trunc: 1};
        tbl[4] = '{nb: 4, maxb: 0, rmode: 1, sid: 16'h0044, exp_out: 5, exp_seq: 1, exp_trunc: 0};
        tbl[5] = '{nb: 2, maxb: 2, rmode: 2, sid: 16'h0055, exp_out: 3, exp_seq: 1, exp_trunc: 0};

        // Table rows: one input packet each, fresh reset per row.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            stream_id = tbl[r].sid;
            max_beats = tbl[r].maxb;
            enable = 1'b1;
            add_packet(tbl[r].nb);
            model_build(in_q, tbl[r].maxb, tbl[r].sid);
            run_stream(tbl[r].rmode, 0, -1);
            chk($sformatf("row%0d_nout", r), 160'(got_q.size()), 160'(tbl[r].exp_out));
            compare_outputs();
            chk($sformatf("row%0d_seq", r), 160'(seq_num), 160'(tbl[r].exp_seq));
            chk($sformatf("row%0d_trunc", r), 160'(trunc_err), 160'(tbl[r].exp_trunc));
        end

        // Back-to-back: three 2-beat packets, headers spaced by 2 payload + idle + header cycles.
        do_reset();
        stream_id = 16'h0007;
        max_beats = 0;
        enable = 1'b1;
        for (int p = 0; p < 3; p++) add_packet(2);
        model_build(in_q, 0, 16'h0007);
        run_stream(0, 0, -1);
        compare_outputs();
        chk("b2b_nhdr", 160'(hdr_cyc.size()), 160'(3));
        if (hdr_cyc.size() == 3) begin
            chk("b2b_gap1", 160'(hdr_cyc[1] - hdr_cyc[0]), 160'(4));
            chk("b2b_gap2", 160'(hdr_cyc[2] - hdr_cyc[1]), 160'(4));
        end

        // Random streams against the packet model, no reset between runs.
        do_reset();
        enable = 1'b1;
        for (int r = 0; r < 10; r++) begin
            stream_id = 16'($urandom);
            max_beats = $urandom_range(0, 4);
            n = $urandom_range(1, 3);
            for (int p = 0; p < n; p++) add_packet($urandom_range(1, 6));
            model_build(in_q, max_beats, stream_id);
            run_stream(2, 30, -1);
            compare_outputs();
            chk($sformatf("rnd%0d_seq", r), 160'(seq_num), 160'(m_seq));
            chk($sformatf("rnd%0d_trunc", r), 160'(trunc_err), 160'(m_trunc));
        end

        // Enable dropped after D1: packet completes, next packet waits for enable.
        do_reset();
        stream_id = 16'h00E1;
        max_beats = 0;
        enable = 1'b1;
        add_packet(4);
        model_build(in_q, 0, 16'h00E1);
        run_stream(0, 0, 2);
        compare_outputs();
        chk("en_seq1", 160'(seq_num), 160'(1));
        add_packet(2);
        model_build(in_q, 0, 16'h00E1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            m_if.tready = 1'b1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = in_q[0].d;
            s_if.tlast  = in_q[0].l;
            #1;
            chk("en_block", {158'h0, m_if.tvalid, s_if.tready}, 160'h0);
        end
        enable = 1'b1;
        run_stream(0, 0, -1);
        compare_outputs();
        chk("en_seq2", 160'(seq_num), 160'(2));

        // Reset in the middle of a payload: outputs and counters drop immediately.
        do_reset();
        stream_id = 16'h00F0;
        max_beats = 2;
        enable = 1'b1;
        add_packet(3);
        model_build(in_q, 2, 16'h00F0);
        run_stream(0, 0, -1);
        compare_outputs();
        chk("pre_rst_seq", 160'(seq_num), 160'(2));
        chk("pre_rst_trunc", 160'(trunc_err), 160'(1));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            m_if.tready = 1'b1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
            s_if.tlast  = 1'b0;
            #1;
            seen = s_if.tready;
        end
        chk("mid_pkt_reached", 160'(seen), 160'(1));
        rst = 1'b1;
        #1;
        chk("arst_ctrl", {157'h0, m_if.tvalid, m_if.tlast, s_if.tready}, 160'h0);
        chk("arst_tdata", 160'(m_if.tdata), 160'h0);
        chk("arst_seq", 160'(seq_num), 160'h0);
        chk("arst_trunc", 160'(trunc_err), 160'h0);
        s_if.tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
